// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver and the downstream key mapper.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam int FRAME_DATA_BITS = 8;

    // Set-2 scan codes used by the game controls; right paddle keys arrive E0-prefixed.
    localparam logic [7:0] SC_BREAK       = 8'hF0;
    localparam logic [7:0] SC_EXTENDED    = 8'hE0;
    localparam logic [7:0] SC_PADDLE_L_UP = 8'h1D;
    localparam logic [7:0] SC_PADDLE_L_DN = 8'h1B;
    localparam logic [7:0] SC_PADDLE_R_UP = 8'h75;
    localparam logic [7:0] SC_PADDLE_R_DN = 8'h72;

    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return (^d) ^ p;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus a run-length filter for one PS/2 line; flags 1->0 transitions
// of the filtered level with a single-cycle strobe.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_vga,
    input  logic rst,
    input  logic line_i,
    output logic level_o,
    output logic fe_o
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic [1:0]    sync_q;
    logic          level_q;
    logic          fe_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_vga) begin
        if (rst) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            fe_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q <= {sync_q[0], line_i};
            fe_q   <= 1'b0;
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                // FILTER_LEN consecutive differing samples: accept the new level
                level_q <= sync_q[1];
                fe_q    <= level_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level_o = level_q;
    assign fe_o    = fe_q;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver (receive only) on clk_vga.
// Define PS2_RX_TIMEOUT_EN to abort partial frames after TIMEOUT_CYCLES without a falling edge.
//
// state     | meaning
// ST_IDLE   | waiting for a start bit on the next falling edge
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | capturing the odd-parity bit
// ST_STOP   | checking stop bit and parity, then publishing the byte
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clk_vga,
    input  logic       rst,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    logic       clk_fe;
    logic       clk_level_unused;
    logic [1:0] dat_sync_q;
    logic       dat_s;

    ps2_state_e state_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] shreg_q;
    logic       par_q;
    logic [7:0] data_q;
    logic       valid_q;
    logic       perr_q;
    logic       ferr_q;
    logic       expired;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk_vga (clk_vga),
        .rst     (rst),
        .line_i  (ps2_clk_in),
        .level_o (clk_level_unused),
        .fe_o    (clk_fe)
    );

    always_ff @(posedge clk_vga) begin
        if (rst) dat_sync_q <= 2'b11;
        else     dat_sync_q <= {dat_sync_q[0], ps2_dat_in};
    end
    assign dat_s = dat_sync_q[1];

`ifdef PS2_RX_TIMEOUT_EN
    logic [12:0] wdog_q;

    always_ff @(posedge clk_vga) begin
        if (rst || clk_fe || state_q == ST_IDLE) wdog_q <= '0;
        else                                     wdog_q <= wdog_q + 1'b1;
    end
    assign expired = (state_q != ST_IDLE) && (wdog_q == 13'(TIMEOUT_CYCLES - 1));
`else
    logic [12:0] timeout_unused;
    assign timeout_unused = 13'(TIMEOUT_CYCLES);
    assign expired        = 1'b0;
`endif

    always_ff @(posedge clk_vga) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            // a falling edge in the expiry cycle wins over the watchdog
            if (clk_fe) begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (!dat_s) begin
                            state_q   <= ST_DATA;
                            bit_cnt_q <= '0;
                        end else begin
                            ferr_q <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        shreg_q <= {dat_s, shreg_q[7:1]};
                        if (bit_cnt_q == 3'(FRAME_DATA_BITS - 1)) state_q <= ST_PARITY;
                        else bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                    ST_PARITY: begin
                        par_q   <= dat_s;
                        state_q <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (!dat_s) begin
                            ferr_q <= 1'b1;
                        end else if (odd_parity_ok(shreg_q, par_q)) begin
                            data_q  <= shreg_q;
                            valid_q <= 1'b1;
                        end else begin
                            perr_q <= 1'b1;
                        end
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end else if (expired) begin
                ferr_q  <= 1'b1;
                state_q <= ST_IDLE;
            end
        end
    end

    assign data       = data_q;
    assign data_valid = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: frames driven at a 40-cycle PS/2 half-period, pulses tallied
// by a negedge monitor, expectations written per scenario.
module tb_ps2_rx;

    localparam int TIMEOUT = 5000;
    localparam int FE_LAT  = 11;   // pad fall to registered pulse: 2 sync + 8 filter + 1 output

    logic       clk_vga = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk_in = 1'b1;
    logic       ps2_dat_in = 1'b1;
    logic [7:0] data;
    logic       data_valid, parity_err, frame_err, busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_fall_cyc = 0;

    int         n_dv = 0, n_pe = 0, n_fe = 0, n_busy = 0;
    int         fe_cyc = 0;
    logic [7:0] last_data = 8'h00, prev_data = 8'h00;
    logic       dv_busy = 1'b0, dv_prev_busy = 1'b0, prev_busy = 1'b0;

    always #5 clk_vga = ~clk_vga;
    always @(posedge clk_vga) cyc <= cyc + 1;

    ps2_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk_vga    (clk_vga),
        .rst        (rst),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .data       (data),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always @(negedge clk_vga) begin
        if (data_valid) begin
            n_dv++;
            prev_data    = last_data;
            last_data    = data;
            dv_busy      = busy;
            dv_prev_busy = prev_busy;
        end
        if (parity_err) n_pe++;
        if (frame_err) begin
            n_fe++;
            fe_cyc = cyc;
        end
        if (busy) n_busy++;
        prev_busy = busy;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_vga);
        #1;
    endtask

    function automatic logic [10:0] mk(input logic [7:0] d, input logic p, input logic s);
        return {s, p, d, 1'b0};
    endfunction

    // data for the next bit is changed in the middle of each low phase
    task automatic send_bits(input logic [10:0] b, input int nbits);
        ps2_dat_in = b[0];
        for (int i = 0; i < nbits; i++) begin
            ps2_clk_in    = 1'b0;
            last_fall_cyc = cyc;
            tick(20);
            ps2_dat_in = (i < nbits - 1) ? b[i+1] : 1'b1;
            tick(20);
            ps2_clk_in = 1'b1;
            tick(40);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(4);
        total++; if (data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", data); end
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_dv got=%b want=0", data_valid); end
        total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL reset_pe got=%b want=0", parity_err); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_fe got=%b want=0", frame_err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        rst = 1'b0;
        tick(20);
    endtask

    task automatic test_single();
        int s_dv = n_dv, s_pe = n_pe, s_fe = n_fe;
        send_bits(mk(8'h1C, 1'b0, 1'b1), 11);
        total++; if (n_dv - s_dv !== 1) begin bad++; $display("FAIL single_dv_count got=%0d want=1", n_dv - s_dv); end
        total++; if (last_data !== 8'h1C) begin bad++; $display("FAIL single_dv_data got=%h want=1c", last_data); end
        total++; if (data !== 8'h1C) begin bad++; $display("FAIL single_data got=%h want=1c", data); end
        total++; if (n_pe - s_pe !== 0) begin bad++; $display("FAIL single_pe got=%0d want=0", n_pe - s_pe); end
        total++; if (n_fe - s_fe !== 0) begin bad++; $display("FAIL single_fe got=%0d want=0", n_fe - s_fe); end
        total++; if (dv_prev_busy !== 1'b1) begin bad++; $display("FAIL single_busy_at_stop got=%b want=1", dv_prev_busy); end
        total++; if (dv_busy !== 1'b0) begin bad++; $display("FAIL single_busy_after_stop got=%b want=0", dv_busy); end
    endtask

    task automatic test_back_to_back();
        int s_dv = n_dv, s_fe = n_fe;
        send_bits(mk(8'hF0, 1'b1, 1'b1), 11);
        send_bits(mk(8'h1C, 1'b0, 1'b1), 11);
        total++; if (n_dv - s_dv !== 2) begin bad++; $display("FAIL b2b_dv_count got=%0d want=2", n_dv - s_dv); end
        total++; if (prev_data !== 8'hF0) begin bad++; $display("FAIL b2b_first got=%h want=f0", prev_data); end
        total++; if (last_data !== 8'h1C) begin bad++; $display("FAIL b2b_second got=%h want=1c", last_data); end
        total++; if (n_fe - s_fe !== 0) begin bad++; $display("FAIL b2b_fe got=%0d want=0", n_fe - s_fe); end
    endtask

    task automatic test_parity();
        int s_dv = n_dv, s_pe = n_pe, s_fe = n_fe;
        send_bits(mk(8'h75, 1'b1, 1'b1), 11);
        total++; if (n_pe - s_pe !== 1) begin bad++; $display("FAIL parity_pe got=%0d want=1", n_pe - s_pe); end
        total++; if (n_dv - s_dv !== 0) begin bad++; $display("FAIL parity_dv got=%0d want=0", n_dv - s_dv); end
        total++; if (n_fe - s_fe !== 0) begin bad++; $display("FAIL parity_fe got=%0d want=0", n_fe - s_fe); end
        total++; if (data !== 8'h1C) begin bad++; $display("FAIL parity_data_kept got=%h want=1c", data); end
    endtask

    task automatic test_frame_err();
        int s_dv = n_dv, s_pe = n_pe, s_fe = n_fe, s_busy;
        send_bits(mk(8'h29, 1'b0, 1'b0), 11);
        total++; if (n_fe - s_fe !== 1) begin bad++; $display("FAIL stop_fe got=%0d want=1", n_fe - s_fe); end
        total++; if (n_pe - s_pe !== 0) begin bad++; $display("FAIL stop_pe got=%0d want=0", n_pe - s_pe); end
        total++; if (n_dv - s_dv !== 0) begin bad++; $display("FAIL stop_dv got=%0d want=0", n_dv - s_dv); end
        total++; if (data !== 8'h1C) begin bad++; $display("FAIL stop_data_kept got=%h want=1c", data); end
        s_fe   = n_fe;
        s_busy = n_busy;
        send_bits(11'h001, 1);
        total++; if (n_fe - s_fe !== 1) begin bad++; $display("FAIL badstart_fe got=%0d want=1", n_fe - s_fe); end
        total++; if (n_busy - s_busy !== 0) begin bad++; $display("FAIL badstart_busy_cycles got=%0d want=0", n_busy - s_busy); end
    endtask

    task automatic test_glitch();
        int s_dv = n_dv, s_pe = n_pe, s_fe = n_fe, s_busy = n_busy;
        ps2_dat_in = 1'b0;
        ps2_clk_in = 1'b0;
        tick(6);
        ps2_clk_in = 1'b1;
        tick(40);
        total++; if (n_busy - s_busy !== 0) begin bad++; $display("FAIL glitch6_busy_cycles got=%0d want=0", n_busy - s_busy); end
        total++; if (n_fe + n_pe + n_dv - s_fe - s_pe - s_dv !== 0) begin bad++; $display("FAIL glitch6_pulses got=%0d want=0", n_fe + n_pe + n_dv - s_fe - s_pe - s_dv); end
        ps2_clk_in = 1'b0;
        tick(8);
        ps2_clk_in = 1'b1;
        tick(40);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL glitch8_start got=%b want=1", busy); end
        total++; if (n_fe - s_fe !== 0) begin bad++; $display("FAIL glitch8_fe got=%0d want=0", n_fe - s_fe); end
        ps2_dat_in = 1'b1;
    endtask

    task automatic test_reset_mid_frame();
        int s_dv = n_dv, s_fe = n_fe;
        send_bits(mk(8'h55, 1'b1, 1'b1), 3);
        rst = 1'b1;
        tick(1);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
        total++; if (data !== 8'h00) begin bad++; $display("FAIL midrst_data got=%h want=00", data); end
        rst = 1'b0;
        tick(20);
        total++; if (n_dv + n_fe - s_dv - s_fe !== 0) begin bad++; $display("FAIL midrst_pulses got=%0d want=0", n_dv + n_fe - s_dv - s_fe); end
    endtask

    task automatic test_timeout();
        int s_dv, s_fe = n_fe;
        send_bits(mk(8'hA5, 1'b1, 1'b1), 4);
`ifdef PS2_RX_TIMEOUT_EN
        tick(TIMEOUT + 100);
        total++; if (n_fe - s_fe !== 1) begin bad++; $display("FAIL timeout_fe got=%0d want=1", n_fe - s_fe); end
        total++; if (fe_cyc - last_fall_cyc !== TIMEOUT + FE_LAT) begin bad++; $display("FAIL timeout_delay got=%0d want=%0d", fe_cyc - last_fall_cyc, TIMEOUT + FE_LAT); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL timeout_busy got=%b want=0", busy); end
`else
        tick(300);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL notimeout_busy got=%b want=1", busy); end
        total++; if (n_fe - s_fe !== 0) begin bad++; $display("FAIL notimeout_fe got=%0d want=0", n_fe - s_fe); end
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(20);
`endif
        s_dv = n_dv;
        send_bits(mk(8'h29, 1'b0, 1'b1), 11);
        total++; if (n_dv - s_dv !== 1) begin bad++; $display("FAIL after_to_dv got=%0d want=1", n_dv - s_dv); end
        total++; if (data !== 8'h29) begin bad++; $display("FAIL after_to_data got=%h want=29", data); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_parity();
        test_frame_err();
        test_glitch();
        test_reset_mid_frame();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
PS/2 device-to-host receiver for the keyboard port (PS2_CLK/PS2_DAT). It deserializes 11-bit frames into 8-bit scan codes for the game controls. The block runs on clk_vga, so no extra clock domain is needed, and it is receive-only: it never drives the PS/2 lines. The top level keeps the PS/2 pads high-Z and feeds the pad values into this block.

Parameters:
- FILTER_LEN, default 8: consecutive identical samples required before the filtered PS/2 clock changes value.
- TIMEOUT_CYCLES, default 5000: clk_vga cycles without a falling edge before a partial frame is aborted (about 200 us at 25 MHz). Used only when PS2_RX_TIMEOUT_EN is defined.

Ports:
- clk_vga  in  1  system clock (VGA pixel clock)
- rst  in  1  synchronous reset, active-high
- ps2_clk_in  in  1  raw PS/2 clock pad value (asynchronous)
- ps2_dat_in  in  1  raw PS/2 data pad value (asynchronous)
- data  out  8  last correctly received byte
- data_valid  out  1  one-cycle pulse when data is updated
- parity_err  out  1  one-cycle pulse on odd-parity failure
- frame_err  out  1  one-cycle pulse on bad start bit, bad stop bit, or timeout
- busy  out  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk_vga. Reset sets data=8'h00, data_valid=0, parity_err=0, frame_err=0, busy=0, state=IDLE, bit counter=0, shift register=0. It also sets both synchronizer chains and the filtered clock to 1 (bus idle high).
- Reset asserted mid-frame discards the partial frame. No pulse is emitted.
- Synchronization: each input passes through a 2-flop synchronizer.
- Clock filter:
  - A counter tracks how long the synced clock has differed from the filtered clock.
  - The filtered clock takes the synced value only after FILTER_LEN consecutive differing samples.
  - Any sample equal to the filtered clock clears the counter.
  - A falling edge is a filtered-clock transition from 1 to 0. It is a one-cycle strobe (fe).
- Data sampling: synced data is sampled in the cycle fe is high.
- State machine (advances only on fe):
  - IDLE: sampled 0 → go to DATA, bit counter=0. Sampled 1 (bad start bit) → frame_err pulse, stay in IDLE.
  - DATA: shift LSB-first, shreg <= {dat, shreg[7:1]}. After the 8th bit (counter==7) → go to PARITY.
  - PARITY: store the parity bit p and go to STOP.
  - STOP, dat=1 and (^shreg ^ p)==1: data<=shreg, data_valid pulse.
  - STOP, dat=1 and parity wrong: parity_err pulse, data unchanged.
  - STOP, dat=0: frame_err pulse only. frame_err takes precedence over parity_err and data is unchanged.
  - STOP always returns to IDLE.
- Pulse timing: all pulses and the data update are registered. They are high for exactly the one cycle following the fe cycle of the deciding bit.
- Back-to-back frames: a start bit that arrives while in IDLE immediately after STOP is accepted. There are no dead cycles.
- ps2_dat_in changing between edges has no effect.

Optional Feature:
- Macro: PS2_RX_TIMEOUT_EN.
- With the macro:
  - A 13-bit watchdog counter clears on every fe and while in IDLE, and counts otherwise.
  - When it reaches TIMEOUT_CYCLES in any non-IDLE state: frame_err pulse, return to IDLE, busy=0 in the following cycle.
  - fe in the same cycle as expiry: the edge wins and the watchdog clears.
- Without the macro: no counter exists, and a truncated frame waits indefinitely for further edges.

Decomposition:
- Shared package ps2_pkg:
  - state encoding for IDLE, DATA, PARITY, STOP
  - FRAME_DATA_BITS=8
  - scan-code constants for the later key mapper: break prefix 8'hF0, extended prefix 8'hE0, and the paddle keys.
- One sub-module, ps2_line_filter: 2-flop synchronizer plus FILTER_LEN filter, outputs the filtered level and the fe strobe. It is instantiated for the clock line. The data line uses a plain 2-flop synchronizer.

Test Plan:
Bench settings: FILTER_LEN=8, PS/2 half-period 40 cycles, data changed mid-low-phase per the device protocol.
1. Frame 8'h1C, parity bit 0, stop bit 1 → exactly one data_valid pulse with data=8'h1C. parity_err=0, frame_err=0. busy high from the start fe until one cycle after the stop fe.
2. Back-to-back frames 8'hF0 (parity 1) then 8'h1C with no idle gap → two data_valid pulses, data=8'hF0 then 8'h1C.
3. Frame 8'h75 with parity bit 1 (wrong) → one parity_err pulse, no data_valid, data keeps the previous value.
4. Frame 8'h29 with stop bit 0 → frame_err pulse, no parity_err, no data_valid. Then start bit sent as 1 → frame_err, state stays IDLE.
5. Glitches on ps2_clk_in while idle:
   - 6-cycle low pulse (FILTER_LEN-2) → no fe, busy stays 0, no pulses.
   - 8-cycle low pulse with data=0 → frame start accepted.
6. Reset and timeout:
   - Start bit plus 3 data bits, then clock held high. With PS2_RX_TIMEOUT_EN: frame_err exactly TIMEOUT_CYCLES after the last fe, busy=0.
   - A following good frame 8'h29 is received correctly.
   - rst asserted mid-frame → busy=0 and data=8'h00 the next cycle.
